clk_div_glitchless: RTL and testbench

- Parametrised successor to the team's integer clock divider. Divides i_ref_clk by a runtime integer ratio of RATIO_W bits.
- Ratio and enable changes take effect only at a divided-period boundary, so the output never glitches.
- Odd ratios are supported, and a one-cycle o_tick strobe is provided for downstream logic in the ref domain.
- Sits in the clock-generation area and feeds UART/serial blocks that need programmable baud clocks.

---
 rtl/clk_div_glitchless_if.sv | 36 +++
 rtl/clk_div_glitchless.sv | 67 ++++++
 tb/tb_clk_div_glitchless.sv | 135 +++++++++++++
 3 files changed

// File: rtl/clk_div_glitchless_if.sv
// Control/status bundle for clk_div_glitchless.
// i_sync is present only when CLK_DIV_SYNC_IN_EN is defined.
interface clk_div_glitchless_if #(
    parameter int unsigned RATIO_W = 8
);
    logic               i_clk_en;
    logic [RATIO_W-1:0] i_div_ratio;
`ifdef CLK_DIV_SYNC_IN_EN
    logic               i_sync;
`endif
    logic               o_div_clk;
    logic               o_tick;
    logic [RATIO_W-1:0] o_ratio_act;

    modport master (
        output i_clk_en,
        output i_div_ratio,
`ifdef CLK_DIV_SYNC_IN_EN
        output i_sync,
`endif
        input  o_div_clk,
        input  o_tick,
        input  o_ratio_act
    );

    modport slave (
        input  i_clk_en,
        input  i_div_ratio,
`ifdef CLK_DIV_SYNC_IN_EN
        input  i_sync,
`endif
        output o_div_clk,
        output o_tick,
        output o_ratio_act
    );
endinterface

// File: rtl/clk_div_glitchless.sv
// Glitch-free runtime-programmable integer clock divider with per-period tick.
// Optional macro CLK_DIV_SYNC_IN_EN adds i_sync to force a period boundary.
module clk_div_glitchless #(
    parameter int unsigned RATIO_W = 8
) (
    input  logic                 i_ref_clk,
    input  logic                 i_rst,
    clk_div_glitchless_if.slave  bus
);

    logic [RATIO_W-1:0] cnt_q, cnt_d;
    logic [RATIO_W-1:0] r_act_q, r_act_d;
    logic [RATIO_W-1:0] half_d;
    logic               en_act_q, en_act_d;
    logic               div_q, div_d;
    logic               tick_q, tick_d;
    logic               bypass;
    logic               boundary;
    logic               reload;

    assign bypass   = ~en_act_q | (r_act_q < RATIO_W'(2));
    assign boundary = (cnt_q == r_act_q - RATIO_W'(1));

    // Shadow registers only reload at a period start, which keeps the output glitch-free.
`ifdef CLK_DIV_SYNC_IN_EN
    assign reload = bypass | boundary | bus.i_sync;
`else
    assign reload = bypass | boundary;
`endif

    always_comb begin
        cnt_d    = cnt_q + RATIO_W'(1);
        r_act_d  = r_act_q;
        en_act_d = en_act_q;
        if (reload) begin
            cnt_d    = '0;
            r_act_d  = bus.i_div_ratio;
            en_act_d = bus.i_clk_en;
        end
        // High phase is ceil(R/2) cycles, judged against the ratio in force for cnt_d.
        half_d = r_act_d - (r_act_d >> 1);
        div_d  = (cnt_d < half_d);
        tick_d = (cnt_d == '0);
    end

    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            cnt_q    <= '0;
            r_act_q  <= '0;
            en_act_q <= 1'b0;
            div_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            r_act_q  <= r_act_d;
            en_act_q <= en_act_d;
            div_q    <= div_d;
            tick_q   <= tick_d;
        end
    end

    // Sole combinational clock path: reference clock passes straight through in bypass.
    assign bus.o_div_clk   = i_rst ? 1'b0 : (bypass ? i_ref_clk : div_q);
    assign bus.o_tick      = tick_q;
    assign bus.o_ratio_act = r_act_q;

endmodule

// File: tb/tb_clk_div_glitchless.sv
// Directed self-checking bench for clk_div_glitchless (10 ns reference clock).
module tb_clk_div_glitchless;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    clk_div_glitchless_if #(.RATIO_W(8)) bus ();

    clk_div_glitchless #(.RATIO_W(8)) dut (
        .i_ref_clk (clk),
        .i_rst     (rst),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect n ref cycles of divide-by-r, with the first edge landing on cnt=start.
    task automatic expect_cycles(input int r, input int start, input int n);
        int c;
        int h;
        h = r - r / 2;
        for (int i = 0; i < n; i++) begin
            c = (start + i) % r;
            step();
            check("div_after_rise", 32'(bus.o_div_clk), 32'(c < h));
            check("tick", 32'(bus.o_tick), 32'(c == 0));
            check("ratio_act", 32'(bus.o_ratio_act), 32'(r));
            @(negedge clk);
            check("div_after_fall", 32'(bus.o_div_clk), 32'(c < h));
        end
    endtask

    // Expect n cycles where the output simply follows the reference clock.
    task automatic expect_bypass(input int r, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("byp_hi", 32'(bus.o_div_clk), 32'd1);
            check("byp_tick", 32'(bus.o_tick), 32'd1);
            check("byp_ratio_act", 32'(bus.o_ratio_act), 32'(r));
            @(negedge clk);
            check("byp_lo", 32'(bus.o_div_clk), 32'd0);
        end
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        rst             = 1'b1;
        bus.i_clk_en    = 1'b0;
        bus.i_div_ratio = 8'd0;
`ifdef CLK_DIV_SYNC_IN_EN
        bus.i_sync      = 1'b0;
`endif
        step();
        step();
        check("rst_div", 32'(bus.o_div_clk), 32'd0);
        check("rst_tick", 32'(bus.o_tick), 32'd0);
        check("rst_ratio_act", 32'(bus.o_ratio_act), 32'd0);

        // Divide by 4 starting straight out of reset.
        rst             = 1'b0;
        bus.i_div_ratio = 8'd4;
        bus.i_clk_en    = 1'b1;
        expect_cycles(4, 0, 8);

        // Divide by 5, then request 10 mid-period: the 50 ns period completes first.
        bus.i_div_ratio = 8'd5;
        expect_cycles(5, 0, 3);
        bus.i_div_ratio = 8'd10;
        expect_cycles(5, 3, 2);
        expect_cycles(10, 0, 20);

        // Disable while dividing by 15: period finishes, then bypass; re-enable resumes.
        bus.i_div_ratio = 8'd15;
        expect_cycles(15, 0, 7);
        bus.i_clk_en = 1'b0;
        expect_cycles(15, 7, 8);
        expect_bypass(15, 3);
        bus.i_clk_en = 1'b1;
        expect_cycles(15, 0, 15);

        // Ratios 0 and 1 bypass; ratio 2 gives a 20 ns period.
        bus.i_div_ratio = 8'd0;
        expect_bypass(0, 3);
        bus.i_div_ratio = 8'd1;
        expect_bypass(1, 3);
        bus.i_div_ratio = 8'd2;
        expect_cycles(2, 0, 6);

        // Reset in the middle of a divide-by-15 period.
        bus.i_div_ratio = 8'd15;
        expect_cycles(15, 0, 6);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("midrst_div", 32'(bus.o_div_clk), 32'd0);
            check("midrst_ratio_act", 32'(bus.o_ratio_act), 32'd0);
            check("midrst_tick", 32'(bus.o_tick), 32'd0);
        end
        rst = 1'b0;
        expect_cycles(15, 0, 15);

`ifdef CLK_DIV_SYNC_IN_EN
        // Sync pulse at cnt=5 of a divide-by-8 period restarts the period with a rising edge.
        bus.i_div_ratio = 8'd8;
        expect_cycles(8, 0, 6);
        bus.i_sync = 1'b1;
        expect_cycles(8, 0, 1);
        bus.i_sync = 1'b0;
        expect_cycles(8, 1, 15);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
